// File: rtl/sha2_pkg.sv
// Shared constants and types for the SHA-2 chunk engine: round constants (with a zero pad entry),
// standard initial hashes, FSM state type and per-width rotation amounts.
package sha2_pkg;

  typedef enum logic [1:0] {StIdle, StCompress, StFinal, StOutput} state_e;

  typedef struct packed {
    int unsigned bs0_r1;
    int unsigned bs0_r2;
    int unsigned bs0_r3;
    int unsigned bs1_r1;
    int unsigned bs1_r2;
    int unsigned bs1_r3;
    int unsigned ss0_r1;
    int unsigned ss0_r2;
    int unsigned ss0_sh;
    int unsigned ss1_r1;
    int unsigned ss1_r2;
    int unsigned ss1_sh;
  } rot_cfg_t;

  function automatic rot_cfg_t rot_cfg(int unsigned word);
    rot_cfg_t r;
    if (word == 32) r = '{2, 13, 22, 6, 11, 25, 7, 18, 3, 17, 19, 10};
    else            r = '{28, 34, 39, 14, 18, 41, 1, 8, 7, 19, 61, 6};
    return r;
  endfunction

  localparam logic [255:0] IV256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [511:0] IV512 = {
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };

  // Trailing zero entry absorbs the hkw precompute issued during the last round.
  localparam logic [31:0] K256 [0:64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2, 32'h00000000
  };

  localparam logic [63:0] K512 [0:80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817,
    64'h0000000000000000
  };

endpackage

// File: rtl/carry_save_adder.sv
// Multi-operand modulo-2^WIDTH adder: a chain of 3:2 compressors feeding one carry-propagate add.
module carry_save_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 3
) (
  input  logic [WIDTH-1:0] op [N],
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH-1:0] s_acc, c_acc, s_nxt;

  always_comb begin
    s_acc = op[0];
    c_acc = op[1];
    s_nxt = '0;
    for (int k = 2; k < N; k++) begin
      s_nxt = s_acc ^ c_acc ^ op[k];
      c_acc = ((s_acc & c_acc) | (s_acc & op[k]) | (c_acc & op[k])) << 1;
      s_acc = s_nxt;
    end
    sum = s_acc + c_acc;
  end

endmodule

// File: rtl/sha2_msg_schedule.sv
// Sliding 16-word message schedule window; w[0] is the word consumed by the current round.
module sha2_msg_schedule
  import sha2_pkg::*;
#(
  parameter int unsigned WORD = 64
) (
  input  logic                 clk,
  input  logic                 breset,
  input  logic                 load,
  input  logic                 shift,
  input  logic [16*WORD-1:0]   chunk,
  output logic [WORD-1:0]      w1,
  output logic [WORD-1:0]      new_w
);

  localparam rot_cfg_t Rot = rot_cfg(WORD);

  function automatic logic [WORD-1:0] rotr(logic [WORD-1:0] x, int unsigned n);
    return (x >> n) | (x << (WORD - n));
  endfunction

  logic [WORD-1:0] w_q [16];
  logic [WORD-1:0] ops [4];

  always_comb begin
    ops[0] = rotr(w_q[1], Rot.ss0_r1) ^ rotr(w_q[1], Rot.ss0_r2) ^ (w_q[1] >> Rot.ss0_sh);
    ops[1] = rotr(w_q[14], Rot.ss1_r1) ^ rotr(w_q[14], Rot.ss1_r2) ^ (w_q[14] >> Rot.ss1_sh);
    ops[2] = w_q[0];
    ops[3] = w_q[9];
  end

  carry_save_adder #(
    .WIDTH (WORD),
    .N     (4)
  ) u_csa_w (
    .op  (ops),
    .sum (new_w)
  );

  always_ff @(posedge clk or negedge breset) begin
    if (!breset) begin
      for (int k = 0; k < 16; k++) w_q[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < 16; k++) w_q[k] <= chunk[(16-k)*WORD-1 -: WORD];
    end else if (shift) begin
      for (int k = 0; k < 15; k++) w_q[k] <= w_q[k+1];
      w_q[15] <= new_w;
    end
  end

  assign w1 = w_q[1];

endmodule

// File: rtl/sha2_chunk_engine.sv
// SHA-2 compression engine (SHA-256 at WORD=32, SHA-512 at WORD=64), one round per clock,
// valid/ready on both sides and an internal chaining register for multi-chunk messages.
module sha2_chunk_engine
  import sha2_pkg::*;
#(
  parameter int unsigned WORD = 64
) (
  input  logic                 clk,
  input  logic                 breset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_first,
  input  logic [16*WORD-1:0]   in_chunk,
  input  logic [8*WORD-1:0]    iv,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*WORD-1:0]    out_hash
);

  localparam int unsigned ROUNDS = (WORD == 32) ? 64 : 80;
  localparam rot_cfg_t    Rot    = rot_cfg(WORD);

  if (WORD != 32 && WORD != 64) begin : g_bad_word
    $error("sha2_chunk_engine: WORD must be 32 or 64");
  end

  function automatic logic [WORD-1:0] rotr(logic [WORD-1:0] x, int unsigned n);
    return (x >> n) | (x << (WORD - n));
  endfunction

  state_e            state_q, state_d;
  logic [6:0]        cnt_q, cnt_d;
  logic [WORD-1:0]   v_q [8];
  logic [WORD-1:0]   base_q [8];
  logic [WORD-1:0]   base_sel [8];
  logic [WORD-1:0]   hkw_q, hkw_sum;
  logic [8*WORD-1:0] chain_q, hash_q, hash_d, base_vec;
  logic              accept, in_compress;

  // FSM
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    accept      = 1'b0;
    in_compress = 1'b0;
    case (state_q)
      StIdle: begin
        in_ready = breset;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = StCompress;
        end
      end
      StCompress: begin
        in_compress = 1'b1;
        cnt_d       = cnt_q + 7'd1;
        if (cnt_q == 7'(ROUNDS - 1)) state_d = StFinal;
      end
      StFinal:  state_d = StOutput;
      StOutput: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default:  state_d = StIdle;
    endcase
  end

  assign base_vec = in_first ? iv : chain_q;

  always_comb begin
    for (int j = 0; j < 8; j++) base_sel[j] = base_vec[(8-j)*WORD-1 -: WORD];
  end

  // Round constant for the hkw precompute: K[0] at accept, K[i+1] during round i.
  logic [6:0]      k_idx;
  logic [WORD-1:0] k_cur;

  assign k_idx = in_compress ? cnt_q + 7'd1 : 7'd0;

  if (WORD == 32) begin : g_k256
    assign k_cur = K256[k_idx];
  end else begin : g_k512
    assign k_cur = K512[k_idx];
  end

  logic [WORD-1:0] w1, new_w;

  sha2_msg_schedule #(
    .WORD (WORD)
  ) u_sched (
    .clk    (clk),
    .breset (breset),
    .load   (accept),
    .shift  (in_compress),
    .chunk  (in_chunk),
    .w1     (w1),
    .new_w  (new_w)
  );

  // Round datapath
  logic [WORD-1:0] bs0, bs1, ch, maj, new_a, new_e;
  logic [WORD-1:0] a_ops [5];
  logic [WORD-1:0] e_ops [4];
  logic [WORD-1:0] k_ops [3];

  always_comb begin
    bs0 = rotr(v_q[0], Rot.bs0_r1) ^ rotr(v_q[0], Rot.bs0_r2) ^ rotr(v_q[0], Rot.bs0_r3);
    bs1 = rotr(v_q[4], Rot.bs1_r1) ^ rotr(v_q[4], Rot.bs1_r2) ^ rotr(v_q[4], Rot.bs1_r3);
    ch  = (v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6]);
    maj = (v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]);
    a_ops = '{hkw_q, bs1, ch, bs0, maj};
    e_ops = '{v_q[3], hkw_q, bs1, ch};
    if (in_compress) k_ops = '{v_q[6], k_cur, w1};
    else             k_ops = '{base_sel[7], k_cur, in_chunk[16*WORD-1 -: WORD]};
  end

  carry_save_adder #(.WIDTH (WORD), .N (5)) u_csa_a (.op (a_ops), .sum (new_a));
  carry_save_adder #(.WIDTH (WORD), .N (4)) u_csa_e (.op (e_ops), .sum (new_e));
  carry_save_adder #(.WIDTH (WORD), .N (3)) u_csa_k (.op (k_ops), .sum (hkw_sum));

  always_comb begin
    hash_d = '0;
    for (int j = 0; j < 8; j++) hash_d[(8-j)*WORD-1 -: WORD] = base_q[j] + v_q[j];
  end

  always_ff @(posedge clk or negedge breset) begin
    if (!breset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hkw_q   <= '0;
      hash_q  <= '0;
      chain_q <= '0;
      for (int j = 0; j < 8; j++) begin
        v_q[j]    <= '0;
        base_q[j] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        for (int j = 0; j < 8; j++) begin
          v_q[j]    <= base_sel[j];
          base_q[j] <= base_sel[j];
        end
        hkw_q <= hkw_sum;
      end else if (in_compress) begin
        v_q[0] <= new_a;
        v_q[1] <= v_q[0];
        v_q[2] <= v_q[1];
        v_q[3] <= v_q[2];
        v_q[4] <= new_e;
        v_q[5] <= v_q[4];
        v_q[6] <= v_q[5];
        v_q[7] <= v_q[6];
        hkw_q  <= hkw_sum;
      end
      if (state_q == StFinal) begin
        hash_q  <= hash_d;
        chain_q <= hash_d;
      end
    end
  end

  assign out_hash = hash_q;

endmodule

// File: tb/tb_sha2_chunk_engine.sv
// Directed bench for sha2_chunk_engine at both widths, with a plain SHA-256 compression model.
module tb_sha2_chunk_engine;
  import sha2_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic breset = 1'b1;

  logic          in_valid64, in_ready64, in_first64, out_valid64, out_ready64;
  logic [1023:0] in_chunk64;
  logic [511:0]  iv64, out_hash64;

  logic          in_valid32, in_ready32, in_first32, out_valid32, out_ready32;
  logic [511:0]  in_chunk32;
  logic [255:0]  iv32, out_hash32;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [1023:0] Abc512 = {64'h6162638000000000, 896'h0, 64'h18};
  localparam logic [511:0]  Abc256 = {32'h61626380, 448'h0, 32'h18};
  localparam logic [511:0]  Gold512 = {
    64'hddaf35a193617aba, 64'hcc417349ae204131, 64'h12e6fa4e89a97ea2, 64'h0a9eeee64b55d39a,
    64'h2192992a274fc1a8, 64'h36ba3c23a3feebbd, 64'h454d4423643ce80e, 64'h2a9ac94fa54ca49f};
  localparam logic [255:0]  Gold256 =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [511:0]  Two1 = 512'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b_696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071_80000000_00000000;
  localparam logic [511:0]  Two2 = {480'h0, 32'h1c0};
  localparam logic [255:0]  GoldTwo =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  sha2_chunk_engine #(.WORD (64)) dut64 (
    .clk       (clk),
    .breset    (breset),
    .in_valid  (in_valid64),
    .in_ready  (in_ready64),
    .in_first  (in_first64),
    .in_chunk  (in_chunk64),
    .iv        (iv64),
    .out_valid (out_valid64),
    .out_ready (out_ready64),
    .out_hash  (out_hash64)
  );

  sha2_chunk_engine #(.WORD (32)) dut32 (
    .clk       (clk),
    .breset    (breset),
    .in_valid  (in_valid32),
    .in_ready  (in_ready32),
    .in_first  (in_first32),
    .in_chunk  (in_chunk32),
    .iv        (iv32),
    .out_valid (out_valid32),
    .out_ready (out_ready32),
    .out_hash  (out_hash32)
  );

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha256_ref(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] hv [8];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (rotr32(w[i-2], 17) ^ rotr32(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7] +
             (rotr32(w[i-15], 7) ^ rotr32(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    for (int j = 0; j < 8; j++) hv[j] = hin[255-32*j -: 32];
    a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3]; e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
    for (int i = 0; i < 64; i++) begin
      t1 = h + (rotr32(e, 6) ^ rotr32(e, 11) ^ rotr32(e, 25)) + ((e & f) ^ (~e & g)) +
           K256[i] + w[i];
      t2 = (rotr32(a, 2) ^ rotr32(a, 13) ^ rotr32(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hv[0] + a, hv[1] + b, hv[2] + c, hv[3] + d,
            hv[4] + e, hv[5] + f, hv[6] + g, hv[7] + h};
  endfunction

  // Presents one chunk to dut32 from a negedge; returns at the first negedge with out_valid high.
  // lat counts cycles from the accept cycle to that one (300 means it never came).
  task automatic run32(input logic first, input logic [511:0] chunk, input logic [255:0] ivv,
                       output logic [255:0] hash, output int lat);
    int n;
    in_first32 = first;
    in_chunk32 = chunk;
    iv32       = ivv;
    in_valid32 = 1'b1;
    n = 0;
    while (!in_ready32 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    in_valid32 = 1'b0;
    lat = 1;
    while (!out_valid32 && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    hash = out_hash32;
  endtask

  task automatic test_reset();
    in_valid64 = 0; in_first64 = 0; in_chunk64 = '0; iv64 = '0; out_ready64 = 0;
    in_valid32 = 0; in_first32 = 0; in_chunk32 = '0; iv32 = '0; out_ready32 = 0;
    #2 breset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (in_ready64 !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready64: got %b expected 0", in_ready64); end
    n_cmp++; if (in_ready32 !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready32: got %b expected 0", in_ready32); end
    n_cmp++; if (out_valid64 !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid64: got %b expected 0", out_valid64); end
    n_cmp++; if (out_valid32 !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid32: got %b expected 0", out_valid32); end
    n_cmp++; if (out_hash64 !== '0) begin n_bad++; $display("FAIL rst_out_hash64: got %h expected 0", out_hash64); end
    n_cmp++; if (out_hash32 !== '0) begin n_bad++; $display("FAIL rst_out_hash32: got %h expected 0", out_hash32); end
    breset = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready64 !== 1'b1) begin n_bad++; $display("FAIL idle_in_ready64: got %b expected 1", in_ready64); end
    n_cmp++; if (in_ready32 !== 1'b1) begin n_bad++; $display("FAIL idle_in_ready32: got %b expected 1", in_ready32); end
  endtask

  task automatic test_abc512();
    int n, lat;
    in_first64 = 1; iv64 = IV512; in_chunk64 = Abc512; out_ready64 = 1; in_valid64 = 1;
    n = 0;
    while (!in_ready64 && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid64 = 0;
    in_chunk64 = '1;
    lat = 1;
    while (!out_valid64 && lat < 300) begin @(negedge clk); lat++; end
    n_cmp++; if (lat !== 82) begin n_bad++; $display("FAIL abc512_latency: got %0d expected 82", lat); end
    n_cmp++; if (out_hash64 !== Gold512) begin n_bad++; $display("FAIL abc512_hash: got %h expected %h", out_hash64, Gold512); end
    @(negedge clk);
    n_cmp++; if (out_valid64 !== 1'b0) begin n_bad++; $display("FAIL abc512_release: out_valid got %b expected 0", out_valid64); end
    n_cmp++; if (in_ready64 !== 1'b1) begin n_bad++; $display("FAIL abc512_ready: got %b expected 1", in_ready64); end
  endtask

  task automatic test_abc256();
    logic [255:0] h;
    int lat;
    out_ready32 = 1;
    run32(1'b1, Abc256, IV256, h, lat);
    n_cmp++; if (lat !== 66) begin n_bad++; $display("FAIL abc256_latency: got %0d expected 66", lat); end
    n_cmp++; if (h !== Gold256) begin n_bad++; $display("FAIL abc256_hash: got %h expected %h", h, Gold256); end
    @(negedge clk);
  endtask

  task automatic test_two_chunk();
    logic [255:0] h, exp1;
    int lat;
    exp1 = sha256_ref(IV256, Two1);
    run32(1'b1, Two1, IV256, h, lat);
    n_cmp++; if (h !== exp1) begin n_bad++; $display("FAIL two_chunk_first: got %h expected %h", h, exp1); end
    @(negedge clk);
    run32(1'b0, Two2, '1, h, lat);
    n_cmp++; if (h !== GoldTwo) begin n_bad++; $display("FAIL two_chunk_second: got %h expected %h", h, GoldTwo); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [255:0] h, exp;
    int lat;
    out_ready32 = 0;
    run32(1'b1, Abc256, IV256, h, lat);
    n_cmp++; if (h !== Gold256) begin n_bad++; $display("FAIL bp_hash: got %h expected %h", h, Gold256); end
    for (int c = 0; c < 20; c++) begin
      if (c == 10) begin
        in_valid32 = 1; in_first32 = 1; in_chunk32 = Two1;
      end else begin
        in_valid32 = 0;
      end
      @(negedge clk);
      n_cmp++; if (out_valid32 !== 1'b1) begin n_bad++; $display("FAIL bp_valid cycle %0d: got %b expected 1", c, out_valid32); end
      n_cmp++; if (out_hash32 !== Gold256) begin n_bad++; $display("FAIL bp_stable cycle %0d: got %h expected %h", c, out_hash32, Gold256); end
      n_cmp++; if (in_ready32 !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready cycle %0d: got %b expected 0", c, in_ready32); end
    end
    out_ready32 = 1;
    @(negedge clk);
    n_cmp++; if (in_ready32 !== 1'b1) begin n_bad++; $display("FAIL bp_resume_ready: got %b expected 1", in_ready32); end
    n_cmp++; if (out_valid32 !== 1'b0) begin n_bad++; $display("FAIL bp_resume_valid: got %b expected 0", out_valid32); end
    // The ignored pulse must not have disturbed the chain.
    exp = sha256_ref(Gold256, Two2);
    run32(1'b0, Two2, '0, h, lat);
    n_cmp++; if (h !== exp) begin n_bad++; $display("FAIL bp_chain: got %h expected %h", h, exp); end
    n_cmp++; if (lat !== 66) begin n_bad++; $display("FAIL bp_chain_latency: got %0d expected 66", lat); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [255:0] h, exp;
    int n, lat;
    out_ready32 = 1; in_first32 = 1; iv32 = IV256; in_chunk32 = Abc256; in_valid32 = 1;
    n = 0;
    while (!in_ready32 && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid32 = 0;
    repeat (40) @(negedge clk);
    breset = 1'b0;
    #1;
    n_cmp++; if (out_valid32 !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b expected 0", out_valid32); end
    n_cmp++; if (in_ready32 !== 1'b0) begin n_bad++; $display("FAIL midrst_ready: got %b expected 0", in_ready32); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (out_valid32 !== 1'b0 || in_ready32 !== 1'b0) begin
        n_bad++; $display("FAIL midrst_hold cycle %0d: valid/ready got %b%b expected 00", c, out_valid32, in_ready32);
      end
    end
    breset = 1'b1;
    @(negedge clk);
    exp = sha256_ref('0, Abc256);
    run32(1'b0, Abc256, IV256, h, lat);
    n_cmp++; if (h !== exp) begin n_bad++; $display("FAIL midrst_zero_base: got %h expected %h", h, exp); end
    n_cmp++; if (lat !== 66) begin n_bad++; $display("FAIL midrst_latency: got %0d expected 66", lat); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [511:0] chunks [8];
    logic [255:0] exp [8];
    logic [255:0] prev;
    int cyc, acc, got, last_acc;
    logic pend;
    prev = IV256;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 16; i++) chunks[k][511-32*i -: 32] = $urandom;
      exp[k] = sha256_ref(prev, chunks[k]);
      prev   = exp[k];
    end
    out_ready32 = 1; in_first32 = 1; iv32 = IV256; in_chunk32 = chunks[0]; in_valid32 = 1;
    cyc = 0; acc = 0; got = 0; last_acc = 0; pend = 0;
    while (got < 8 && cyc < 1000) begin
      if (pend) begin
        if (acc < 8) begin in_chunk32 = chunks[acc]; in_first32 = 0; end
        else in_valid32 = 0;
        pend = 0;
      end
      if (out_valid32) begin
        n_cmp++; if (out_hash32 !== exp[got]) begin n_bad++; $display("FAIL b2b_hash %0d: got %h expected %h", got, out_hash32, exp[got]); end
        got++;
      end
      if (in_valid32 && in_ready32) begin
        if (acc > 0) begin
          n_cmp++; if (cyc - last_acc !== 67) begin n_bad++; $display("FAIL b2b_spacing %0d: got %0d expected 67", acc, cyc - last_acc); end
        end
        last_acc = cyc;
        acc++;
        pend = 1;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid32 = 0;
    n_cmp++; if (got !== 8) begin n_bad++; $display("FAIL b2b_count: got %0d results expected 8", got); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_abc512();
    test_abc256();
    test_two_chunk();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
